// File: rtl/dump_axis_packer_if.sv
// AXI4-Stream k2h link between the dump packer (master) and the host-facing consumer (slave).
interface dump_axis_packer_if #(
  parameter int unsigned AXIS_TDATA_WIDTH = 512,
  parameter int unsigned TDEST_WIDTH      = 16
);
  logic                          tvalid;
  logic                          tready;
  logic [AXIS_TDATA_WIDTH-1:0]   tdata;
  logic [AXIS_TDATA_WIDTH/8-1:0] tkeep;
  logic                          tlast;
  logic [TDEST_WIDTH-1:0]        tdest;

  modport master (output tvalid, tdata, tkeep, tlast, tdest, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tdest, output tready);
endinterface

// File: rtl/dump_axis_packer.sv
// Kernel-to-host dump engine: scans PC entries, drops empty ones, emits one terminated AXIS packet.
// Define DUMP_PACKER_COUNT_EN to add the o_dump_words handshaken-word counter.
module dump_axis_packer #(
  parameter int unsigned AXIS_TDATA_WIDTH = 512,
  parameter int unsigned TDEST_WIDTH      = 16,
  parameter int unsigned PC_ADDR_WIDTH    = 10,
  parameter int unsigned EMPTY_BIT        = 226
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_dump_start,
  input  logic [PC_ADDR_WIDTH:0]      i_dump_len,
  input  logic [TDEST_WIDTH-1:0]      i_dump_tdest,
  output logic                        o_dump_busy,
  output logic                        o_dump_done,
  output logic                        o_pc_rd_en,
  output logic [PC_ADDR_WIDTH-1:0]    o_pc_rd_addr,
  input  logic [AXIS_TDATA_WIDTH-1:0] i_pc_rd_data,
  dump_axis_packer_if.master          m_axis_k2h
`ifdef DUMP_PACKER_COUNT_EN
  ,
  output logic [PC_ADDR_WIDTH:0]      o_dump_words
`endif
);

  localparam logic [AXIS_TDATA_WIDTH-1:0] EmptyMarkerWord =
    {{(AXIS_TDATA_WIDTH-1){1'b0}}, 1'b1} << EMPTY_BIT;

  typedef enum logic [2:0] {StIdle, StScan, StFlush, StEmpty, StDone} state_e;

  state_e                      state_q;
  logic [PC_ADDR_WIDTH:0]      len_q;
  logic [PC_ADDR_WIDTH:0]      rd_cnt_q;
  logic                        inflight_q;
  logic [TDEST_WIDTH-1:0]      tdest_q;
  logic                        pend_valid_q;
  logic [AXIS_TDATA_WIDTH-1:0] pend_data_q;
  logic                        out_valid_q;
  logic                        out_last_q;
  logic [AXIS_TDATA_WIDTH-1:0] out_data_q;

  logic out_fire;
  logic ret_valid;
  logic rd_issue;

  assign out_fire  = out_valid_q & m_axis_k2h.tready;
  assign ret_valid = inflight_q & ~i_pc_rd_data[EMPTY_BIT];

  // Only read when the returning word is guaranteed a home: either the pending slot is free,
  // or the output register will be empty when the word lands so the pending word can move up.
  assign rd_issue = (state_q == StScan) && !inflight_q && (rd_cnt_q < len_q) &&
                    (!pend_valid_q || !out_valid_q || out_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      len_q        <= '0;
      rd_cnt_q     <= '0;
      inflight_q   <= 1'b0;
      tdest_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_dump_start) begin
            len_q        <= i_dump_len;
            tdest_q      <= i_dump_tdest;
            rd_cnt_q     <= '0;
            inflight_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            state_q      <= (i_dump_len == '0) ? StEmpty : StScan;
          end
        end
        StScan: begin
          if (out_fire) out_valid_q <= 1'b0;
          inflight_q <= rd_issue;
          if (rd_issue) rd_cnt_q <= rd_cnt_q + 1'b1;
          // One-word lookahead: the pending word is released only once a newer valid word exists.
          if (ret_valid) begin
            pend_data_q  <= i_pc_rd_data;
            pend_valid_q <= 1'b1;
            if (pend_valid_q) begin
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
              out_data_q  <= pend_data_q;
            end
          end
          if ((rd_cnt_q == len_q) && !inflight_q) state_q <= StFlush;
        end
        StFlush, StEmpty: begin
          if (out_fire && out_last_q) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= StDone;
          end else if (!out_last_q && (!out_valid_q || out_fire)) begin
            out_valid_q  <= 1'b1;
            out_last_q   <= 1'b1;
            out_data_q   <= pend_valid_q ? pend_data_q : EmptyMarkerWord;
            pend_valid_q <= 1'b0;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_dump_busy  = (state_q != StIdle);
  assign o_dump_done  = (state_q == StDone);
  assign o_pc_rd_en   = rd_issue;
  assign o_pc_rd_addr = rd_cnt_q[PC_ADDR_WIDTH-1:0];

  assign m_axis_k2h.tvalid = out_valid_q;
  assign m_axis_k2h.tdata  = out_data_q;
  assign m_axis_k2h.tlast  = out_last_q;
  assign m_axis_k2h.tdest  = tdest_q;
  assign m_axis_k2h.tkeep  = {(AXIS_TDATA_WIDTH/8){out_valid_q}};

`ifdef DUMP_PACKER_COUNT_EN
  logic [PC_ADDR_WIDTH:0] words_q;

  // Real PC words never carry EMPTY_BIT, so that bit marks the empty-dump word.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
    end else if ((state_q == StIdle) && i_dump_start) begin
      words_q <= '0;
    end else if (out_fire && !out_data_q[EMPTY_BIT]) begin
      words_q <= words_q + 1'b1;
    end
  end

  assign o_dump_words = words_q;
`endif

endmodule
